// File: rtl/va_defs.sv
// Shared definitions for the video shifter: default transfer delay, word length
// and the 2-bit colour codes used in colour mode.
package va_defs;

  localparam int XFER_DLY_DEF = 4;
  localparam int WORD_LEN     = 16;

  typedef logic [WORD_LEN-1:0] word_t;

  typedef enum logic [1:0] {
    BLACK = 2'b00,
    BLUE  = 2'b01,
    GREEN = 2'b10,
    RED   = 2'b11
  } color_code_t;

endpackage

// File: rtl/va_dly.sv
// Fixed-depth single-bit delay line with a configurable reset value.
module va_dly #(
  parameter int   DEPTH   = 5,
  parameter logic RST_VAL = 1'b1
) (
  input  logic CLKIN,
  input  logic RESET,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] pipe;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge CLKIN) begin
        if (RESET) pipe <= {DEPTH{RST_VAL}};
        else       pipe <= din;
      end
    end else begin : g_chain
      always_ff @(posedge CLKIN) begin
        if (RESET) pipe <= {DEPTH{RST_VAL}};
        else       pipe <= {pipe[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/va_shifter.sv
// Video shifter: double-buffered 16-bit word, 2 bits per clock out as mono pairs
// or one-hot colour, with composite sync delayed to match the pixel latency.
module va_shifter
  import va_defs::*;
#(
  parameter int XFER_DLY = XFER_DLY_DEF,
  parameter int SYNC_DLY = XFER_DLY + 1
) (
  input  logic                PIN_CLK,
  input  logic                PIN_R,
  input  logic                PIN_WTI,
  input  logic [WORD_LEN-1:0] PIN_D,
  input  logic                PIN_COLOR,
  input  logic                PIN_nVSYNC,
  output logic [1:0]          PIN_MONO,
  output logic                PIN_RED,
  output logic                PIN_GRN,
  output logic                PIN_BLU,
  output logic                PIN_nSYNCO,
  output logic                PIN_OVR
);

  logic       wti_prev;
  logic       pending;
  logic [2:0] cnt;
  logic       mode;
  word_t      hold;
  word_t      shifter;
  logic       sync_d;
  logic       wti_rise;
  logic       xfer;

  assign wti_rise = PIN_WTI & ~wti_prev;
  assign xfer     = pending && (cnt == 3'd0);

  // An edge landing on the transfer clock is not an overrun: the old word
  // still reaches the shifter on that same clock.
  always_ff @(posedge PIN_CLK) begin
    if (PIN_R) begin
      wti_prev <= 1'b1;
      pending  <= 1'b0;
      cnt      <= 3'd0;
      mode     <= 1'b0;
      hold     <= '0;
      shifter  <= '0;
      PIN_OVR  <= 1'b0;
    end else begin
      wti_prev <= PIN_WTI;
      if (xfer) begin
        shifter <= hold;
        mode    <= PIN_COLOR;
      end else begin
        shifter <= {2'b00, shifter[WORD_LEN-1:2]};
      end
      if (wti_rise) begin
        hold    <= PIN_D;
        pending <= 1'b1;
        cnt     <= 3'(XFER_DLY - 1);
        if (pending && !xfer) PIN_OVR <= 1'b1;
      end else if (xfer) begin
        pending <= 1'b0;
      end else if (pending) begin
        cnt <= cnt - 3'd1;
      end
    end
  end

  va_dly #(
    .DEPTH  (SYNC_DLY),
    .RST_VAL(1'b1)
  ) u_sync_dly (
    .CLKIN(PIN_CLK),
    .RESET(PIN_R),
    .din  (PIN_nVSYNC),
    .dout (sync_d)
  );

  // Sync and pixels share this output register so blanking lines up exactly
  // with the delayed sync.
  always_ff @(posedge PIN_CLK) begin
    if (PIN_R) begin
      PIN_MONO   <= 2'b00;
      PIN_RED    <= 1'b0;
      PIN_GRN    <= 1'b0;
      PIN_BLU    <= 1'b0;
      PIN_nSYNCO <= 1'b1;
    end else begin
      PIN_nSYNCO <= sync_d;
      PIN_MONO   <= 2'b00;
      PIN_RED    <= 1'b0;
      PIN_GRN    <= 1'b0;
      PIN_BLU    <= 1'b0;
      if (sync_d) begin
        if (mode) begin
          case (shifter[1:0])
            BLUE:    PIN_BLU <= 1'b1;
            GREEN:   PIN_GRN <= 1'b1;
            RED:     PIN_RED <= 1'b1;
            default: ;
          endcase
        end else begin
          PIN_MONO <= shifter[1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_va_shifter.sv
// Scoreboard bench for va_shifter: directed vectors push expected outputs per
// cycle, a negedge monitor pops and compares them.
module tb_va_shifter;

  logic        PIN_CLK = 1'b0;
  logic        PIN_R;
  logic        PIN_WTI;
  logic [15:0] PIN_D;
  logic        PIN_COLOR;
  logic        PIN_nVSYNC;
  logic [1:0]  PIN_MONO;
  logic        PIN_RED;
  logic        PIN_GRN;
  logic        PIN_BLU;
  logic        PIN_nSYNCO;
  logic        PIN_OVR;

  int cyc    = 0;
  int base   = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [1:0] mono;
    logic       red;
    logic       grn;
    logic       blu;
    logic       nsync;
    logic       ovr;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  va_shifter dut (
    .PIN_CLK   (PIN_CLK),
    .PIN_R     (PIN_R),
    .PIN_WTI   (PIN_WTI),
    .PIN_D     (PIN_D),
    .PIN_COLOR (PIN_COLOR),
    .PIN_nVSYNC(PIN_nVSYNC),
    .PIN_MONO  (PIN_MONO),
    .PIN_RED   (PIN_RED),
    .PIN_GRN   (PIN_GRN),
    .PIN_BLU   (PIN_BLU),
    .PIN_nSYNCO(PIN_nSYNCO),
    .PIN_OVR   (PIN_OVR)
  );

  always #5 PIN_CLK = ~PIN_CLK;

  always @(posedge PIN_CLK) cyc <= cyc + 1;

  // Monitor: pops every expectation due at this cycle and compares it.
  always @(negedge PIN_CLK) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("[TB] FAIL %s: due at cycle %0d, monitor already at %0d", e.tag, e.cyc - base, cyc - base);
      end else if ({PIN_MONO, PIN_RED, PIN_GRN, PIN_BLU, PIN_nSYNCO, PIN_OVR} !==
                   {e.mono, e.red, e.grn, e.blu, e.nsync, e.ovr}) begin
        errors++;
        $display("[TB] FAIL %s @%0d: got mono=%b r=%b g=%b b=%b nsync=%b ovr=%b, want mono=%b r=%b g=%b b=%b nsync=%b ovr=%b",
                 e.tag, cyc - base, PIN_MONO, PIN_RED, PIN_GRN, PIN_BLU, PIN_nSYNCO, PIN_OVR,
                 e.mono, e.red, e.grn, e.blu, e.nsync, e.ovr);
      end
    end
  end

  task automatic checkOutput(input string tag, input int rel, input logic [1:0] mono,
                             input logic red, input logic grn, input logic blu,
                             input logic nsync, input logic ovr);
    exp_t e;
    e.cyc = base + rel; e.mono = mono; e.red = red; e.grn = grn; e.blu = blu;
    e.nsync = nsync; e.ovr = ovr; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic checkMono(input string tag, input int rel, input logic [1:0] mono, input logic ovr);
    checkOutput(tag, rel, mono, 1'b0, 1'b0, 1'b0, 1'b1, ovr);
  endtask

  // Drives a full input vector so that it is sampled on relative edge rel.
  task automatic applyStimulus(input int rel, input logic r, input logic wti, input logic [15:0] d,
                               input logic color, input logic nvsync);
    int target;
    target = base + rel - 1;
    if (cyc > target) begin
      checks++;
      errors++;
      $display("[TB] FAIL stim_late: at cycle %0d, wanted %0d", cyc - base, rel - 1);
    end
    while (cyc < target) begin
      @(posedge PIN_CLK);
      #1;
    end
    PIN_R = r; PIN_WTI = wti; PIN_D = d; PIN_COLOR = color; PIN_nVSYNC = nvsync;
  endtask

  task automatic doReset(input logic wti, input logic [15:0] d);
    PIN_R = 1'b1; PIN_WTI = wti; PIN_D = d; PIN_COLOR = 1'b0; PIN_nVSYNC = 1'b1;
    @(posedge PIN_CLK); #1;
    @(posedge PIN_CLK); #1;
    PIN_R = 1'b0;
    base = cyc;
    checkOutput("reset", 0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) begin
      @(posedge PIN_CLK);
      #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    // Mono single word: one lit pixel pair, then blank.
    doReset(1'b0, 16'h0000);
    checkMono("mono_first", 15, 2'b01, 1'b0);
    for (int i = 16; i <= 22; i++) checkMono("mono_blank", i, 2'b00, 1'b0);
    applyStimulus(10, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1);
    applyStimulus(11, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    drain();

    // Colour word; COLOR drops mid-word and must not affect it.
    doReset(1'b0, 16'h0000);
    checkOutput("col_black", 15, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("col_blue",  16, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("col_green", 17, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("col_red",   18, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("col_tail",  19, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("col_tail",  20, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(10, 1'b0, 1'b1, 16'h00E4, 1'b1, 1'b1);
    applyStimulus(11, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    applyStimulus(16, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    drain();

    // Back-to-back words every 8 clocks: continuous output, no overrun.
    doReset(1'b0, 16'h0000);
    for (int i = 15; i <= 46; i++) checkMono("b2b_on", i, 2'b11, 1'b0);
    checkMono("b2b_end", 47, 2'b00, 1'b0);
    for (int k = 10; k <= 34; k += 8) begin
      applyStimulus(k,     1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
      applyStimulus(k + 1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    end
    drain();

    // Overrun: second word 3 clocks after the first replaces it.
    doReset(1'b0, 16'h0000);
    checkMono("ovr_pre",   12, 2'b00, 1'b0);
    checkMono("ovr_set",   13, 2'b00, 1'b1);
    checkMono("ovr_nold",  15, 2'b00, 1'b1);
    checkMono("ovr_nold",  16, 2'b00, 1'b1);
    checkMono("ovr_nold",  17, 2'b00, 1'b1);
    checkMono("ovr_w0",    18, 2'b00, 1'b1);
    checkMono("ovr_w1",    19, 2'b11, 1'b1);
    checkMono("ovr_w2",    20, 2'b00, 1'b1);
    checkMono("ovr_stick", 30, 2'b00, 1'b1);
    applyStimulus(10, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b1);
    applyStimulus(11, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(13, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b1);
    applyStimulus(14, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    drain();

    // Sync pulse during active data blanks the matching output clock.
    doReset(1'b0, 16'h0000);
    checkMono("sync_before", 24, 2'b11, 1'b0);
    checkOutput("sync_low",  25, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkMono("sync_after",  26, 2'b11, 1'b0);
    applyStimulus(10, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    applyStimulus(11, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(18, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    applyStimulus(19, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(20, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    applyStimulus(21, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    drain();

    // Reset mid-word with a second word pending: nothing survives it.
    doReset(1'b0, 16'h0000);
    checkMono("rst_live", 15, 2'b11, 1'b0);
    checkMono("rst_live", 16, 2'b11, 1'b0);
    checkOutput("rst_hit", 17, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 18; i <= 30; i++) checkMono("rst_quiet", i, 2'b00, 1'b0);
    applyStimulus(10, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    applyStimulus(11, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(15, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    applyStimulus(16, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(17, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(18, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    drain();

    // WTI already high at reset release is not an edge; a later edge works.
    doReset(1'b1, 16'hFFFF);
    for (int i = 1; i <= 10; i++) checkMono("wti_held", i, 2'b00, 1'b0);
    checkMono("wti_fresh", 15, 2'b11, 1'b0);
    applyStimulus(9,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(10, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    applyStimulus(11, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/va_shifter.md
VA_SHIFTER -- requirements
Module: va_shifter

Interface
REQ-001 SHALL have parameter XFER_DLY, default 4, meaning the number of clocks from WTI edge detection to the holding-to-shifter transfer (legal range 1..7).
REQ-002 SHALL have parameter SYNC_DLY, default XFER_DLY+1, meaning the sync pipeline depth, equal to the pixel latency.
REQ-003 SHALL have port PIN_CLK, input, 1 bit: the single clock (pixel/2), with all logic on its rising edge.
REQ-004 SHALL have port PIN_R, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port PIN_WTI, input, 1 bit: video word load strobe from the DRAM controller.
REQ-006 SHALL have port PIN_D, input, 16 bits: the DRAM read data word, non-inverted, valid while PIN_WTI is high.
REQ-007 SHALL have port PIN_COLOR, input, 1 bit: mode select, 1 = 2-bit colour, 0 = monochrome.
REQ-008 SHALL have port PIN_nVSYNC, input, 1 bit: composite sync from the controller, active-low.
REQ-009 SHALL have port PIN_MONO, output, 2 bits: two monochrome pixels per clock; bit 0 is the earlier (left) pixel.
REQ-010 SHALL have ports PIN_RED, PIN_GRN and PIN_BLU, outputs, 1 bit each: colour pixel, one per clock.
REQ-011 SHALL have port PIN_nSYNCO, output, 1 bit: composite sync delayed by SYNC_DLY clocks.
REQ-012 SHALL have port PIN_OVR, output, 1 bit: sticky overrun flag.

Function
REQ-013 SHALL detect a WTI rising edge as PIN_WTI=1 sampled while the previous sample was 0; a strobe held high for several clocks SHALL count as one edge.
REQ-014 SHALL, on a detected edge at cycle n, load PIN_D into a 16-bit holding register, set a pending flag and load the down-counter with XFER_DLY-1.
REQ-015 SHALL, at cycle n+XFER_DLY with pending set, load the holding register into the 16-bit shifter, capture PIN_COLOR into the mode register and clear pending.
REQ-016 SHALL otherwise shift the shifter right by 2 bits per clock, zero-filled, so that an unreplenished word blanks after 8 clocks.
REQ-017 SHALL, when a transfer and a shift fall on the same clock, perform the transfer and drop the shift.
REQ-018 SHALL, when a new edge arrives while pending is set, overwrite the holding register, restart the delay and set PIN_OVR; PIN_OVR clears only on reset.
REQ-019 SHALL register all pixel outputs from the shifter's low 2 bits: a word loaded at cycle n SHALL present its first pair at cycle n+XFER_DLY+1.
REQ-020 SHALL, in mono mode, drive PIN_MONO with bits[1:0] and hold RED, GRN and BLU at 0.
REQ-021 SHALL, in colour mode, map bits[1:0] as 00 black, 01 BLU, 10 GRN, 11 RED (one-hot), with PIN_MONO=00.
REQ-022 SHALL pass PIN_nVSYNC through a SYNC_DLY-stage shift pipeline to PIN_nSYNCO.
REQ-023 SHALL force all pixel outputs to 0 on any clock where the delayed sync is 0.
REQ-024 SHALL take a mode change on PIN_COLOR effect only at the next transfer, never mid-word.
REQ-025 SHALL handle back-to-back edges spaced exactly 8 clocks apart with no gap and no OVR.

Reset
REQ-026 SHALL, while PIN_R=1 at a clock edge, clear holding, shifter, pending, counter, mode, edge history and OVR, and set the sync pipeline to all 1.
REQ-027 SHALL, in the cycle after reset, hold all pixel outputs at 0, PIN_nSYNCO at 1 and PIN_OVR at 0.
REQ-028 SHALL cancel any pending transfer when reset occurs mid-word; no stale data SHALL appear afterwards.
REQ-029 SHALL NOT detect an edge on the first clock after reset release if WTI is already high, because edge history resets to 1.

Structure
REQ-030 SHALL place the XFER_DLY default, the colour code constants (BLACK=00, BLUE=01, GREEN=10, RED=11) and the word length of 16 in the shared va_defs include.
REQ-031 SHALL implement the sync pipeline as one sub-module, va_dly, parameterised by depth and reset value; everything else SHALL stay in va_shifter.

Verification
REQ-032 SHALL verify: mono, D=16'h0001, WTI edge at cycle 10 -> MONO=01 at cycle 15, 00 at cycles 16-22.
REQ-033 SHALL verify: colour, D=16'h00E4, edge at cycle 10 -> black, blue, green, red at cycles 15-18, black afterwards.
REQ-034 SHALL verify: edges every 8 clocks with D=16'hFFFF in mono -> MONO=11 continuously from the first output, OVR=0.
REQ-035 SHALL verify: second edge 3 clocks after the first (D=16'h0003 then 16'h000C) -> only 16'h000C is shown, and OVR=1 until reset.
REQ-036 SHALL verify: PIN_nVSYNC low at cycle 20 during active data -> nSYNCO low at cycle 25, with pixels forced to 0 that cycle.
REQ-037 SHALL verify: PIN_R asserted 3 clocks after a transfer -> the next clock shows all outputs 0, nSYNCO=1, and no pixel output until a fresh WTI edge.
